// File: rtl/lsu_byte_master.sv
// lsu_byte_master: byte-serial RV32 load/store initiator.
// Takes one load/store request and runs it as 1, 2 or 4 single-byte memory
// transactions. Then it returns one response beat with the assembled and
// extended load data, or the store completion.
// Optional build macro LSU_MISALIGN_TRAP_EN rejects misaligned halfword and
// word accesses without touching memory. When it is undefined they run byte by byte.
module lsu_byte_master #(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_f3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              busy,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_ack
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t              state_reg;
  logic                we_reg;
  logic [2:0]          f3_reg;
  logic [ADDR_W-1:0]   addr_reg;
  logic [31:0]         wdata_reg;
  logic [1:0]          idx_reg;
  logic [1:0]          last_idx_reg;
  logic [31:0]         buf_reg;

  logic                f3_legal;
  logic                misaligned;
  logic                reject;
  logic [1:0]          req_last_idx;
  logic [1:0]          idx_next;
  logic [ADDR_W-1:0]   addr_next;
  logic [7:0]          wdata_next;
  logic [31:0]         buf_merged;
  logic [31:0]         load_ext;

  // Decide whether the incoming funct3 is a legal encoding for its direction
  always_comb begin
    f3_legal = 1'b0;
    if (req_we) begin
      f3_legal = (req_f3 == 3'b000) || (req_f3 == 3'b001) || (req_f3 == 3'b010);
    end else begin
      f3_legal = (req_f3 == 3'b000) || (req_f3 == 3'b001) || (req_f3 == 3'b010) ||
                 (req_f3 == 3'b100) || (req_f3 == 3'b101);
    end
  end

`ifdef LSU_MISALIGN_TRAP_EN
  // Halfwords need an even address and words need a 4-byte aligned address
  always_comb begin
    misaligned = 1'b0;
    if (req_f3[1:0] == 2'b01) begin
      misaligned = req_addr[0];
    end else if (req_f3[1:0] == 2'b10) begin
      misaligned = (req_addr[1:0] != 2'b00);
    end
  end
`else
  // Byte-serial access makes every alignment legal
  always_comb begin
    misaligned = 1'b0;
  end
`endif

  assign reject = !f3_legal || misaligned;

  // Index of the final byte: size code 00/01/10 gives 1/2/4 bytes
  always_comb begin
    case (req_f3[1:0])
      2'b00:   req_last_idx = 2'd0;
      2'b01:   req_last_idx = 2'd1;
      default: req_last_idx = 2'd3;
    endcase
  end

  assign idx_next   = idx_reg + 2'd1;
  assign addr_next  = addr_reg + ADDR_W'(idx_next);
  assign wdata_next = wdata_reg[{idx_next, 3'b000} +: 8];

  // Buffer view with the byte being acknowledged already dropped into place,
  // so that the final byte can go straight into the response register
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_merge
      assign buf_merged[8*gi +: 8] = (idx_reg == 2'(gi)) ? mem_rdata : buf_reg[8*gi +: 8];
    end
  endgenerate

  // Sign or zero extend the assembled bytes according to the load type
  always_comb begin
    case (f3_reg)
      3'b000:  load_ext = {{24{buf_merged[7]}}, buf_merged[7:0]};
      3'b001:  load_ext = {{16{buf_merged[15]}}, buf_merged[15:0]};
      3'b010:  load_ext = buf_merged;
      3'b100:  load_ext = {24'd0, buf_merged[7:0]};
      3'b101:  load_ext = {16'd0, buf_merged[15:0]};
      default: load_ext = 32'd0;
    endcase
  end

  // Control FSM with every output registered
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= IDLE;
      we_reg       <= 1'b0;
      f3_reg       <= 3'd0;
      addr_reg     <= '0;
      wdata_reg    <= 32'd0;
      idx_reg      <= 2'd0;
      last_idx_reg <= 2'd0;
      buf_reg      <= 32'd0;
      req_ready    <= 1'b1;
      rsp_valid    <= 1'b0;
      rsp_rdata    <= 32'd0;
      rsp_err      <= 1'b0;
      busy         <= 1'b0;
      mem_en       <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= 8'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          rsp_valid <= 1'b0;
          rsp_err   <= 1'b0;
          rsp_rdata <= 32'd0;
          if (req_valid && req_ready) begin
            we_reg       <= req_we;
            f3_reg       <= req_f3;
            addr_reg     <= req_addr;
            wdata_reg    <= req_wdata;
            idx_reg      <= 2'd0;
            last_idx_reg <= req_last_idx;
            buf_reg      <= 32'd0;
            req_ready    <= 1'b0;
            busy         <= 1'b1;
            if (reject) begin
              // Rejected requests never reach memory
              state_reg <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
            end else begin
              state_reg <= XFER;
              mem_en    <= 1'b1;
              mem_we    <= req_we;
              mem_addr  <= req_addr;
              mem_wdata <= req_wdata[7:0];
            end
          end
        end

        XFER: begin
          if (mem_ack) begin
            if (!we_reg) begin
              buf_reg <= buf_merged;
            end
            if (idx_reg == last_idx_reg) begin
              state_reg <= RESP;
              mem_en    <= 1'b0;
              mem_we    <= 1'b0;
              mem_addr  <= '0;
              mem_wdata <= 8'd0;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b0;
              rsp_rdata <= we_reg ? 32'd0 : load_ext;
            end else begin
              idx_reg   <= idx_next;
              mem_addr  <= addr_next;
              mem_wdata <= wdata_next;
            end
          end
        end

        RESP: begin
          state_reg <= IDLE;
          rsp_valid <= 1'b0;
          rsp_err   <= 1'b0;
          rsp_rdata <= 32'd0;
          busy      <= 1'b0;
          req_ready <= 1'b1;
        end

        default: begin
          state_reg <= IDLE;
          busy      <= 1'b0;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_byte_master.sv
// tb_lsu_byte_master: randomized and directed bench for lsu_byte_master.
// A behavioural byte memory answers the DUT. A separate reference memory and
// transaction model give the expected data, errors and latencies.
module tb_lsu_byte_master;

  localparam int AW    = 6;
  localparam int MEMSZ = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [2:0]    req_f3 = 3'd0;
  logic [AW-1:0] req_addr = '0;
  logic [31:0]   req_wdata = 32'd0;
  logic          rsp_valid;
  logic [31:0]   rsp_rdata;
  logic          rsp_err;
  logic          busy;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;
  logic [7:0]    mem_rdata = 8'd0;
  logic          mem_ack = 1'b0;

  lsu_byte_master #(.ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_f3(req_f3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .busy(busy), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] mem     [MEMSZ];
  logic [7:0] ref_mem [MEMSZ];

  int   mem_delay   = 0;
  int   cyc         = 0;
  logic rst_at_edge = 1'b0;
  int   log_addr[$];
  int   log_data[$];
  int   log_cyc[$];
  int   mem_en_seen = 0;
  int   stable_err  = 0;
  int   rsp_cnt     = 0;

  logic       ack_pending = 1'b0;
  int         pend_addr, pend_cyc, wait_cnt = 0;
  logic       pend_we;
  logic [7:0] pend_wdata;
  logic [AW-1:0] first_addr;
  logic       first_we;
  logic [7:0] first_wdata;

  // Cycle counter and the reset level seen by each rising edge
  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
    rst_at_edge = rst;
  end

  // Response pulse monitor
  initial forever begin
    @(negedge clk);
    if (rsp_valid === 1'b1) rsp_cnt = rsp_cnt + 1;
  end

  // Byte memory: acks after mem_delay wait cycles and commits a byte only if the
  // intervening rising edge was out of reset
  initial forever begin
    @(negedge clk);
    if (ack_pending && rst_at_edge) begin
      if (pend_we) mem[pend_addr] = pend_wdata;
      log_addr.push_back(pend_addr);
      log_data.push_back(int'(pend_wdata));
      log_cyc.push_back(pend_cyc);
    end
    ack_pending = 1'b0;
    if (!rst) begin
      mem_ack  = 1'b0;
      wait_cnt = 0;
    end else if (mem_en === 1'b1) begin
      mem_en_seen = mem_en_seen + 1;
      if (wait_cnt == 0) begin
        first_addr  = mem_addr;
        first_we    = mem_we;
        first_wdata = mem_wdata;
      end else if (mem_addr !== first_addr || mem_we !== first_we || mem_wdata !== first_wdata) begin
        stable_err = stable_err + 1;
      end
      if (wait_cnt >= mem_delay) begin
        mem_ack     = 1'b1;
        mem_rdata   = mem[mem_addr];
        ack_pending = 1'b1;
        pend_addr   = int'(mem_addr);
        pend_we     = mem_we;
        pend_wdata  = mem_wdata;
        pend_cyc    = cyc;
        wait_cnt    = 0;
      end else begin
        mem_ack   = 1'b0;
        mem_rdata = 8'($urandom);
        wait_cnt  = wait_cnt + 1;
      end
    end else begin
      // The DUT must ignore a stray ack outside a byte transfer
      mem_ack   = 1'($urandom_range(0, 1));
      mem_rdata = 8'($urandom);
      wait_cnt  = 0;
    end
  end

  function automatic int mem_diffs();
    int d = 0;
    for (int i = 0; i < MEMSZ; i++) if (mem[i] !== ref_mem[i]) d++;
    return d;
  endfunction

  // Reference transaction model: legality, memory side effects and the response value
  task automatic ref_txn(input logic we, input logic [2:0] f3, input int addr, input logic [31:0] wdata,
                         output logic [31:0] rdata, output logic err, output int nb);
    bit     legal;
    longint val;
    int     n;
    n = 1 << f3[1:0];
    legal = we ? (f3 < 3) : (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
`ifdef LSU_MISALIGN_TRAP_EN
    if (legal && (addr % n) != 0) legal = 0;
`endif
    rdata = 32'd0;
    err   = !legal;
    nb    = legal ? n : 0;
    if (!legal) return;
    if (we) begin
      for (int i = 0; i < n; i++) ref_mem[(addr + i) % MEMSZ] = 8'((wdata >> (8 * i)) & 32'hFF);
    end else begin
      val = 0;
      for (int i = 0; i < n; i++) val += longint'(ref_mem[(addr + i) % MEMSZ]) << (8 * i);
      if (f3 < 4 && n < 4 && val >= (longint'(1) << (8 * n - 1))) val -= longint'(1) << (8 * n);
      rdata = 32'(val);
    end
  endtask

  // Drive one request and collect what the DUT did; comparisons are done by the caller
  task automatic run_req(input logic we, input logic [2:0] f3, input logic [AW-1:0] addr,
                         input logic [31:0] wdata, input int dly,
                         output logic [31:0] rdata, output logic err, output int lat,
                         output int t0, output int ready_bad, output logic post_ok);
    mem_delay = dly;
    rdata     = 32'd0;
    err       = 1'b0;
    lat       = -1;
    ready_bad = 0;
    post_ok   = 1'b0;
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = we;
    req_f3    = f3;
    req_addr  = addr;
    req_wdata = wdata;
    t0        = cyc;
    @(negedge clk);
    req_valid = 1'b0;
    req_we    = 1'($urandom);
    req_f3    = 3'($urandom);
    req_addr  = AW'($urandom);
    req_wdata = $urandom;
    for (int k = 1; k <= 400; k++) begin
      if (rsp_valid === 1'b1) begin
        rdata = rsp_rdata;
        err   = rsp_err;
        lat   = k;
        break;
      end
      if (req_ready !== 1'b0 || busy !== 1'b1) ready_bad++;
      @(negedge clk);
    end
    if (lat > 0) begin
      @(negedge clk);
      #1;
      post_ok = (rsp_valid === 1'b0) && (req_ready === 1'b1) && (busy === 1'b0);
    end
    $display("[TB] txn we=%0d f3=%0d addr=0x%02h wdata=0x%08h dly=%0d -> lat=%0d rdata=0x%08h err=%0b",
             we, f3, addr, wdata, dly, lat, rdata, err);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_tests++;
    if (req_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_ready: got %b want 1", req_ready);
    end
    n_tests++;
    if ({rsp_valid, rsp_err, busy, mem_en, mem_we} !== 5'b0 || rsp_rdata !== 32'd0 ||
        mem_addr !== '0 || mem_wdata !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got v=%b e=%b busy=%b en=%b we=%b rd=%h a=%h wd=%h want all 0",
               rsp_valid, rsp_err, busy, mem_en, mem_we, rsp_rdata, mem_addr, mem_wdata);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    n_tests++;
    if (req_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_release: got ready=%b busy=%b want 1/0", req_ready, busy);
    end
  endtask

  task automatic test_store_word();
    logic [31:0] rd, erd;
    logic        er, eer, pok;
    int          lat, t0, rb, nb;
    logic [7:0]  exp_b [4];
    exp_b[0] = 8'hEF; exp_b[1] = 8'hBE; exp_b[2] = 8'hAD; exp_b[3] = 8'hDE;
    log_addr.delete(); log_data.delete(); log_cyc.delete();
    ref_txn(1'b1, 3'b010, 4, 32'hDEADBEEF, erd, eer, nb);
    run_req(1'b1, 3'b010, 6'h04, 32'hDEADBEEF, 0, rd, er, lat, t0, rb, pok);
    n_tests++;
    if (lat !== 5) begin n_fail++; $display("FAIL sw_latency: got %0d want 5", lat); end
    n_tests++;
    if (er !== 1'b0 || rd !== 32'd0) begin
      n_fail++; $display("FAIL sw_response: got err=%b rdata=%h want 0/0", er, rd);
    end
    n_tests++;
    if (log_addr.size() != 4) begin
      n_fail++; $display("FAIL sw_byte_count: got %0d want 4", log_addr.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_tests++;
        if (log_addr[i] != 4 + i || log_data[i] != int'(exp_b[i]) || log_cyc[i] != t0 + 1 + i) begin
          n_fail++;
          $display("FAIL sw_byte%0d: got 0x%02h@%0d cyc %0d want 0x%02h@%0d cyc %0d",
                   i, log_data[i], log_addr[i], log_cyc[i], exp_b[i], 4 + i, t0 + 1 + i);
        end
      end
    end
    n_tests++;
    if (!pok || mem_diffs() != 0) begin
      n_fail++; $display("FAIL sw_after: got post_ok=%b diffs=%0d want 1/0", pok, mem_diffs());
    end
  endtask

  task automatic test_loads();
    logic [2:0]    f3s [5];
    logic [AW-1:0] ads [5];
    logic [31:0]   exps [5];
    logic [31:0]   rd;
    logic          er, pok;
    int            lat, t0, rb;
    f3s[0] = 3'b000; ads[0] = 6'd7; exps[0] = 32'hFFFFFFDE;
    f3s[1] = 3'b100; ads[1] = 6'd7; exps[1] = 32'h000000DE;
    f3s[2] = 3'b001; ads[2] = 6'd6; exps[2] = 32'hFFFFDEAD;
    f3s[3] = 3'b101; ads[3] = 6'd6; exps[3] = 32'h0000DEAD;
    f3s[4] = 3'b010; ads[4] = 6'd4; exps[4] = 32'hDEADBEEF;
    for (int i = 0; i < 5; i++) begin
`ifdef LSU_MISALIGN_TRAP_EN
      if (i == 2 || i == 3) continue;
`endif
      run_req(1'b0, f3s[i], ads[i], $urandom, 0, rd, er, lat, t0, rb, pok);
      n_tests++;
      if (rd !== exps[i] || er !== 1'b0 || !pok) begin
        n_fail++;
        $display("FAIL load%0d_f3_%0d: got rdata=%h err=%b post_ok=%b want %h/0/1", i, f3s[i], rd, er, pok, exps[i]);
      end
    end
  endtask

  task automatic test_wait_states();
    logic [31:0] rd;
    logic        er, pok;
    int          lat, t0, rb, st0;
    st0 = stable_err;
    run_req(1'b0, 3'b010, 6'h04, 32'd0, 2, rd, er, lat, t0, rb, pok);
    n_tests++;
    if (lat !== 13 || rd !== 32'hDEADBEEF || er !== 1'b0) begin
      n_fail++; $display("FAIL lw_wait: got lat=%0d rdata=%h err=%b want 13/deadbeef/0", lat, rd, er);
    end
    n_tests++;
    if (stable_err != st0 || rb != 0) begin
      n_fail++; $display("FAIL lw_wait_hold: got unstable=%0d ready_busy_bad=%0d want 0/0", stable_err - st0, rb);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] rd, erd;
    logic        er, eer, pok;
    int          lat, t0, rb, nb;
    log_addr.delete(); log_data.delete(); log_cyc.delete();
    ref_txn(1'b1, 3'b001, 63, 32'h00001234, erd, eer, nb);
    run_req(1'b1, 3'b001, 6'h3F, 32'h00001234, 0, rd, er, lat, t0, rb, pok);
`ifdef LSU_MISALIGN_TRAP_EN
    n_tests++;
    if (er !== 1'b1 || lat !== 1) begin
      n_fail++; $display("FAIL wrap_sh_trap: got err=%b lat=%0d want 1/1", er, lat);
    end
`else
    n_tests++;
    if (log_addr.size() != 2 || log_addr[0] != 63 || log_data[0] != 'h34 ||
        log_addr[1] != 0 || log_data[1] != 'h12) begin
      n_fail++;
      $display("FAIL wrap_sh_bytes: got %0d bytes, first 0x%02h@%0d want 0x34@63 then 0x12@0",
               log_addr.size(), log_data.size() > 0 ? log_data[0] : -1, log_addr.size() > 0 ? log_addr[0] : -1);
    end
    run_req(1'b0, 3'b101, 6'h3F, 32'd0, 0, rd, er, lat, t0, rb, pok);
    n_tests++;
    if (rd !== 32'h00001234 || er !== 1'b0) begin
      n_fail++; $display("FAIL wrap_lhu: got rdata=%h err=%b want 00001234/0", rd, er);
    end
`endif
  endtask

  task automatic test_illegal();
    logic [31:0] rd;
    logic        er, pok;
    int          lat, t0, rb, en0;
    logic        wes [2];
    logic [2:0]  f3s [2];
    wes[0] = 1'b0; f3s[0] = 3'b011;
    wes[1] = 1'b1; f3s[1] = 3'b100;
    for (int i = 0; i < 2; i++) begin
      en0 = mem_en_seen;
      run_req(wes[i], f3s[i], 6'(i * 8 + 1), $urandom, 0, rd, er, lat, t0, rb, pok);
      n_tests++;
      if (lat !== 1 || er !== 1'b1 || rd !== 32'd0 || mem_en_seen != en0 || !pok) begin
        n_fail++;
        $display("FAIL illegal_f3_%0d: got lat=%0d err=%b rdata=%h mem_en_cycles=%0d want 1/1/0/0",
                 f3s[i], lat, er, rd, mem_en_seen - en0);
      end
    end
  endtask

`ifdef LSU_MISALIGN_TRAP_EN
  task automatic test_misalign();
    logic [31:0] rd;
    logic        er, pok;
    int          lat, t0, rb, en0;
    en0 = mem_en_seen;
    run_req(1'b0, 3'b010, 6'h05, 32'd0, 0, rd, er, lat, t0, rb, pok);
    n_tests++;
    if (lat !== 1 || er !== 1'b1 || rd !== 32'd0 || mem_en_seen != en0) begin
      n_fail++;
      $display("FAIL misalign_lw: got lat=%0d err=%b rdata=%h mem_en_cycles=%0d want 1/1/0/0",
               lat, er, rd, mem_en_seen - en0);
    end
  endtask
`endif

  task automatic test_reset_abort();
    logic [31:0] w, rd, erd;
    logic        er, eer, pok;
    int          lat, t0, rb, nb, r0;
    w  = $urandom;
    r0 = rsp_cnt;
    log_addr.delete(); log_data.delete(); log_cyc.delete();
    mem_delay = 0;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_f3 = 3'b010; req_addr = 6'd8; req_wdata = w;
    @(negedge clk);
    req_valid = 1'b0;
    for (int k = 0; k < 20 && log_addr.size() < 2; k++) begin
      @(negedge clk);
      #1;
    end
    n_tests++;
    if (log_addr.size() != 2) begin
      n_fail++; $display("FAIL abort_two_bytes: got %0d bytes want 2", log_addr.size());
    end
    rst = 1'b0;
    #1;
    n_tests++;
    if (mem_en !== 1'b0 || rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL abort_mem_en: got mem_en=%b rsp_valid=%b want 0/0", mem_en, rsp_valid);
    end
    ref_mem[8] = w[7:0];
    ref_mem[9] = w[15:8];
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    n_tests++;
    if (req_ready !== 1'b1 || rsp_cnt != r0 || log_addr.size() != 2 || mem_diffs() != 0) begin
      n_fail++;
      $display("FAIL abort_after: got ready=%b rsp_pulses=%0d bytes=%0d mem_diffs=%0d want 1/0/2/0",
               req_ready, rsp_cnt - r0, log_addr.size(), mem_diffs());
    end
    ref_txn(1'b0, 3'b010, 8, 32'd0, erd, eer, nb);
    run_req(1'b0, 3'b010, 6'd8, 32'd0, 0, rd, er, lat, t0, rb, pok);
    n_tests++;
    if (rd !== erd || er !== 1'b0 || lat !== 5) begin
      n_fail++; $display("FAIL abort_next_lw: got rdata=%h err=%b lat=%0d want %h/0/5", rd, er, lat, erd);
    end
  endtask

  task automatic test_random();
    logic          we, er, eer, pok;
    logic [2:0]    f3;
    logic [AW-1:0] ad;
    logic [31:0]   wd, rd, erd;
    int            dly, lat, t0, rb, nb, elat;
    for (int i = 0; i < 40; i++) begin
      we  = 1'($urandom);
      f3  = 3'($urandom);
      ad  = AW'($urandom);
      wd  = $urandom;
      dly = $urandom_range(0, 2);
      ref_txn(we, f3, int'(ad), wd, erd, eer, nb);
      elat = eer ? 1 : nb * (dly + 1) + 1;
      run_req(we, f3, ad, wd, dly, rd, er, lat, t0, rb, pok);
      n_tests++;
      if (rd !== erd || er !== eer || lat !== elat || !pok || rb != 0 || mem_diffs() != 0) begin
        n_fail++;
        $display("FAIL rand%0d: got rdata=%h err=%b lat=%0d post_ok=%b ready_bad=%0d diffs=%0d want %h/%b/%0d/1/0/0",
                 i, rd, er, lat, pok, rb, mem_diffs(), erd, eer, elat);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < MEMSZ; i++) begin
      mem[i]     = 8'($urandom);
      ref_mem[i] = mem[i];
    end
    test_reset();
    test_store_word();
    test_loads();
    test_wait_states();
    test_wrap();
    test_illegal();
`ifdef LSU_MISALIGN_TRAP_EN
    test_misalign();
`endif
    test_reset_abort();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
